// File: rtl/fila_flow_ctrl_if.sv
// Handshake and status bundle shared by the fila flow controller, the fila and the deserializer.
interface fila_flow_ctrl_if #(
    parameter int LEN_W  = 8,
    parameter int DROP_W = 8
);
    logic              data_ready;
    logic [LEN_W-1:0]  len_out;
    logic              dequeue_req;
    logic              enqueue_in;
    logic              ack_in;
    logic              dequeue_in;
    logic              full;
    logic              empty;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        input  data_ready, len_out, dequeue_req,
        output enqueue_in, ack_in, dequeue_in, full, empty, drop_cnt
    );

    modport slave (
        output data_ready, len_out, dequeue_req,
        input  enqueue_in, ack_in, dequeue_in, full, empty, drop_cnt
    );
endinterface

// File: rtl/fila_flow_ctrl.sv
// Moves bytes from the deserializer into fila and arbitrates dequeue against enqueue.
// Optional FILA_DROP_EN: a full-queue stall lasting TIMEOUT cycles acks and discards the byte.
module fila_flow_ctrl #(
    parameter int DEPTH   = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int DROP_W  = 8
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    fila_flow_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, DEQ, ENQ, ACK} state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t state;
    logic   enqueue_q;
    logic   ack_q;
    logic   dequeue_q;
    logic   full_q;
    logic   empty_q;
    logic   pend_deq;
    logic   dreq_q;
    logic   dreq_rise;
    logic   has_room;
    logic   has_data;

    assign dreq_rise = bus.dequeue_req & ~dreq_q;
    assign has_room  = bus.len_out < DEPTH_L;
    assign has_data  = bus.len_out != '0;

`ifdef FILA_DROP_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0]     stall_tmr;
    logic [DROP_W-1:0] drop_q;
    logic              stall;

    assign stall = bus.data_ready & full_q;
`endif

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state     <= IDLE;
            enqueue_q <= 1'b0;
            ack_q     <= 1'b0;
            dequeue_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            pend_deq  <= 1'b0;
            dreq_q    <= 1'b0;
`ifdef FILA_DROP_EN
            stall_tmr <= '0;
            drop_q    <= '0;
`endif
        end else begin
            dreq_q    <= bus.dequeue_req;
            full_q    <= ~has_room;
            empty_q   <= ~has_data;
            enqueue_q <= 1'b0;
            dequeue_q <= 1'b0;
            ack_q     <= 1'b0;
`ifdef FILA_DROP_EN
            stall_tmr <= '0;
`endif
            // Edges on an empty queue are discarded; the DEQ branch below wins over a same-cycle set.
            if (dreq_rise && has_data) begin
                pend_deq <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pend_deq && has_data) begin
                        state     <= DEQ;
                        dequeue_q <= 1'b1;
                    end else if (bus.data_ready && has_room) begin
                        state     <= ENQ;
                        enqueue_q <= 1'b1;
`ifdef FILA_DROP_EN
                    end else if (stall) begin
                        if (stall_tmr == TW'(TIMEOUT - 1)) begin
                            state <= ACK;
                            ack_q <= 1'b1;
                            if (drop_q != '1) begin
                                drop_q <= drop_q + DROP_W'(1);
                            end
                        end else begin
                            stall_tmr <= stall_tmr + TW'(1);
                        end
`endif
                    end
                end
                DEQ: begin
                    pend_deq <= 1'b0;
                    state    <= IDLE;
                end
                ENQ: begin
                    state <= ACK;
                    ack_q <= 1'b1;
                end
                ACK: begin
                    if (bus.data_ready) begin
                        ack_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.enqueue_in = enqueue_q;
    assign bus.ack_in     = ack_q;
    assign bus.dequeue_in = dequeue_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
`ifdef FILA_DROP_EN
    assign bus.drop_cnt   = drop_q;
`else
    assign bus.drop_cnt   = '0;
`endif
endmodule
